// File: rtl/adc_multislope_seq_if.sv
// Host-side bundle of the multi-slope ADC sequencer: control, handshake and result registers.
// Carries the timeout flag only when ADC_RUNDOWN_TIMEOUT_EN is defined.
interface adc_multislope_seq_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             continuous;
    logic             ack;
    logic [CNT_W-1:0] count_pos;
    logic [CNT_W-1:0] count_neg;
    logic [CNT_W-1:0] count_rundown;
    logic             rundown_dir;
    logic             valid;
    logic             overrun;
    logic             irq;
    logic             busy;
`ifdef ADC_RUNDOWN_TIMEOUT_EN
    logic             timeout;

    modport master (
        output start, continuous, ack,
        input  count_pos, count_neg, count_rundown, rundown_dir,
        input  valid, overrun, irq, busy, timeout
    );
    modport slave (
        input  start, continuous, ack,
        output count_pos, count_neg, count_rundown, rundown_dir,
        output valid, overrun, irq, busy, timeout
    );
`else
    modport master (
        output start, continuous, ack,
        input  count_pos, count_neg, count_rundown, rundown_dir,
        input  valid, overrun, irq, busy
    );
    modport slave (
        input  start, continuous, ack,
        output count_pos, count_neg, count_rundown, rundown_dir,
        output valid, overrun, irq, busy
    );
`endif
endinterface

// File: rtl/adc_multislope_seq.sv
// Multi-slope integrating ADC sequencer: short, N-phase runup, rundown to zero crossing.
// Optional rundown timeout enabled by defining ADC_RUNDOWN_TIMEOUT_EN.
module adc_multislope_seq #(
    parameter int         CNT_W       = 32,
    parameter int         PHASE_CLKS  = 10000,
    parameter int         N_PHASES    = 10000,
    parameter int         RESET_CLKS  = 1000,
    parameter logic [2:0] MUX_OFF     = 3'b000,
    parameter logic [2:0] MUX_POS     = 3'b001,
    parameter logic [2:0] MUX_NEG     = 3'b010,
    parameter logic [2:0] MUX_SHORT   = 3'b100,
    parameter int         RUNDOWN_MAX = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmpr_in,
    output logic [2:0]          mux,
    output logic                cmpr_latch,
    adc_multislope_seq_if.slave bus
);
    localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(PHASE_CLKS - 1);
    localparam logic [CNT_W-1:0] SH_LAST = CNT_W'(RESET_CLKS - 1);
    localparam logic [CNT_W-1:0] PN_LAST = CNT_W'(N_PHASES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHORT,
        S_RUNUP,
        S_RUNDOWN,
        S_DONE
    } state_t;

    state_t           state;
    logic             cmp_meta, cmp_s, cmp_hist;
    logic             cmp_cross, cross_ok, rd_tmo;
    logic [CNT_W-1:0] tmr, phase_cnt, pos_w, neg_w, rd_cnt;
    logic             dir_w;
    logic [CNT_W-1:0] cnt_pos, cnt_neg, cnt_rd;
    logic             dir_r, valid_r, overrun_r, irq_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
            cmp_hist <= 1'b0;
        end else begin
            cmp_meta <= cmpr_in;
            cmp_s    <= cmp_meta;
            cmp_hist <= cmp_s;
        end
    end

    assign cmp_cross = cmp_s ^ cmp_hist;
    // The first rundown clock still sees edges left over from the last runup phase.
    assign cross_ok  = cmp_cross && (rd_cnt != '0);

`ifdef ADC_RUNDOWN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RUNDOWN_MAX - 1);
    logic timeout_r;
    assign rd_tmo      = !cross_ok && (rd_cnt == RD_LAST);
    assign bus.timeout = timeout_r;
`else
    assign rd_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mux        <= MUX_OFF;
            cmpr_latch <= 1'b1;
            tmr        <= '0;
            phase_cnt  <= '0;
            pos_w      <= '0;
            neg_w      <= '0;
            rd_cnt     <= '0;
            dir_w      <= 1'b0;
            cnt_pos    <= '0;
            cnt_neg    <= '0;
            cnt_rd     <= '0;
            dir_r      <= 1'b0;
            valid_r    <= 1'b0;
            overrun_r  <= 1'b0;
            irq_r      <= 1'b0;
`ifdef ADC_RUNDOWN_TIMEOUT_EN
            timeout_r  <= 1'b0;
`endif
        end else begin
            irq_r <= 1'b0;
            if (bus.ack) begin
                valid_r   <= 1'b0;
                overrun_r <= 1'b0;
`ifdef ADC_RUNDOWN_TIMEOUT_EN
                timeout_r <= 1'b0;
`endif
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_SHORT;
                        mux   <= MUX_SHORT;
                        tmr   <= '0;
                    end
                end

                S_SHORT: begin
                    pos_w     <= '0;
                    neg_w     <= '0;
                    phase_cnt <= '0;
                    if (tmr == SH_LAST) begin
                        state      <= S_RUNUP;
                        mux        <= MUX_POS;
                        cmpr_latch <= 1'b0;
                        tmr        <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                // Decision at the phase's last clock; mux switches on the boundary edge.
                S_RUNUP: begin
                    if (tmr == PH_LAST) begin
                        tmr       <= '0;
                        phase_cnt <= phase_cnt + 1'b1;
                        dir_w     <= cmp_s;
                        if (cmp_s) begin
                            mux   <= MUX_NEG;
                            neg_w <= neg_w + 1'b1;
                        end else begin
                            mux   <= MUX_POS;
                            pos_w <= pos_w + 1'b1;
                        end
                        if (phase_cnt == PN_LAST) begin
                            state  <= S_RUNDOWN;
                            rd_cnt <= '0;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end

                S_RUNDOWN: begin
                    if (rd_cnt != '1)
                        rd_cnt <= rd_cnt + 1'b1;
                    if (cross_ok || rd_tmo) begin
                        state      <= S_DONE;
                        mux        <= MUX_OFF;
                        cmpr_latch <= 1'b1;
                        cnt_pos    <= pos_w;
                        cnt_neg    <= neg_w;
                        cnt_rd     <= rd_tmo ? '1 : rd_cnt;
                        dir_r      <= dir_w;
                        irq_r      <= 1'b1;
                        valid_r    <= 1'b1;
                        // A same-cycle ack consumes the old result, so nothing is lost.
                        overrun_r  <= !bus.ack && (overrun_r || valid_r);
`ifdef ADC_RUNDOWN_TIMEOUT_EN
                        if (rd_tmo)
                            timeout_r <= 1'b1;
`endif
                    end
                end

                S_DONE: begin
                    if (bus.continuous) begin
                        state <= S_SHORT;
                        mux   <= MUX_SHORT;
                        tmr   <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    mux        <= MUX_OFF;
                    cmpr_latch <= 1'b1;
                end
            endcase
        end
    end

    assign bus.count_pos     = cnt_pos;
    assign bus.count_neg     = cnt_neg;
    assign bus.count_rundown = cnt_rd;
    assign bus.rundown_dir   = dir_r;
    assign bus.valid         = valid_r;
    assign bus.overrun       = overrun_r;
    assign bus.irq           = irq_r;
    assign bus.busy          = (state != S_IDLE);
endmodule

// File: tb/tb_adc_multislope_seq.sv
// Directed bench for adc_multislope_seq with 4 phases of 8 clocks and a 4-clock short.
// Inputs change and outputs are sampled on the falling edge.
module tb_adc_multislope_seq;
    localparam int         CNT_W  = 32;
    localparam int         PH     = 8;
    localparam int         NP     = 4;
    localparam int         RC     = 4;
    localparam int         RD_MAX = 50;
    localparam logic [2:0] M_OFF  = 3'b000;
    localparam logic [2:0] M_POS  = 3'b001;
    localparam logic [2:0] M_NEG  = 3'b010;
    localparam logic [2:0] M_SHT  = 3'b100;

    logic       clk, rst_n, cmpr_in;
    logic [2:0] mux;
    logic       cmpr_latch;
    int         n_cmp, n_err, irq_cnt;

    adc_multislope_seq_if #(.CNT_W(CNT_W)) bus ();

    adc_multislope_seq #(
        .CNT_W(CNT_W), .PHASE_CLKS(PH), .N_PHASES(NP), .RESET_CLKS(RC),
        .MUX_OFF(M_OFF), .MUX_POS(M_POS), .MUX_NEG(M_NEG), .MUX_SHORT(M_SHT),
        .RUNDOWN_MAX(RD_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmpr_in(cmpr_in),
        .mux(mux), .cmpr_latch(cmpr_latch), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // irq is registered, so the posedge sees the value of the cycle just ended.
    always @(posedge clk) if (bus.irq === 1'b1) irq_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        tick(1);
        bus.ack = 1'b0;
    endtask

    // Entered one clock into SHORT; leaves one clock after DONE.
    // d[i] is the comparator level for runup phase i; k < 0 means no crossing at all.
    task automatic run_conv(input logic [3:0] d, input bit glitch, input int k, input bit ack_lat);
        logic [2:0]       exp_mux;
        logic [CNT_W-1:0] exp_rd;
        logic             prev;
        int               irq0;
        irq0 = irq_cnt;
        prev = 1'b0;
        chk("short_first", mux, M_SHT);
        tick(RC - 1);
        chk("short_last", mux, M_SHT);
        tick(1);
        chk("runup_latch", cmpr_latch, 1'b0);
        for (int i = 0; i < NP; i++) begin
            exp_mux = prev ? M_NEG : M_POS;
            cmpr_in = d[i];
            chk("phase_first", mux, exp_mux);
            tick(3);
            if (i == 1) bus.start = 1'b1;
            tick(1);
            bus.start = 1'b0;
            tick(2);
            if (glitch && i == NP - 1) cmpr_in = ~cmpr_in;
            tick(1);
            chk("phase_last", mux, exp_mux);
            tick(1);
            prev = d[i];
        end
        chk("rundown_mux", mux, prev ? M_NEG : M_POS);
        if (k < 0) begin
            tick(RD_MAX);
            exp_rd = '1;
        end else begin
            // Two synchroniser edges to cmp_s, then one edge to accept the crossing.
            tick(k);
            cmpr_in = ~cmpr_in;
            tick(2);
            chk("no_early_done", bus.busy, 1'b1);
            if (ack_lat) bus.ack = 1'b1;
            tick(1);
            bus.ack = 1'b0;
            exp_rd = CNT_W'(k + 2);
        end
        chk("valid_set", bus.valid, 1'b1);
        chk("irq_hi", bus.irq, 1'b1);
        chk("mux_off", mux, M_OFF);
        chk("latch_hold", cmpr_latch, 1'b1);
        chk("cnt_neg", bus.count_neg, $countones(d));
        chk("cnt_pos", bus.count_pos, NP - $countones(d));
        chk("cnt_rundown", bus.count_rundown, exp_rd);
        chk("rundown_dir", bus.rundown_dir, prev);
        tick(1);
        chk("irq_lo", bus.irq, 1'b0);
        chk("irq_once", irq_cnt - irq0, 1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; irq_cnt = 0;
        rst_n = 1'b0; cmpr_in = 1'b1;
        bus.start = 1'b0; bus.continuous = 1'b0; bus.ack = 1'b0;
        tick(2);
        chk("rst_mux", mux, M_OFF);
        chk("rst_latch", cmpr_latch, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_ovr", bus.overrun, 1'b0);
        chk("rst_irq", bus.irq, 1'b0);
        chk("rst_cnt", bus.count_rundown, 0);
        rst_n = 1'b1;
        tick(3);

        // Comparator stuck high: all decisions negative, crossing lands at rundown count 20.
        do_start();
        run_conv(4'b1111, 1'b0, 18, 1'b0);
        chk("idle_after", bus.busy, 1'b0);
        do_ack();
        chk("ack_valid", bus.valid, 1'b0);

        // Alternating phases; a crossing on the first rundown clock must be ignored.
        do_start();
        run_conv(4'b0101, 1'b1, 3, 1'b0);
        do_ack();

        // Continuous mode without ack, continuous dropped during the second conversion.
        bus.continuous = 1'b1;
        do_start();
        run_conv(4'b0011, 1'b0, 6, 1'b0);
        chk("cont_restart", bus.busy, 1'b1);
        chk("ovr_first", bus.overrun, 1'b0);
        bus.continuous = 1'b0;
        run_conv(4'b1000, 1'b0, 10, 1'b0);
        chk("ovr_second", bus.overrun, 1'b1);
        chk("cont_stop", bus.busy, 1'b0);
        do_ack();
        chk("ack_valid2", bus.valid, 1'b0);
        chk("ack_ovr", bus.overrun, 1'b0);

        // Unacked result, then ack coinciding with the next latch: new result wins.
        do_start();
        run_conv(4'b0110, 1'b0, 1, 1'b0);
        chk("ovr_none", bus.overrun, 1'b0);
        do_start();
        run_conv(4'b1110, 1'b0, 0, 1'b1);
        chk("acklat_valid", bus.valid, 1'b1);
        chk("acklat_ovr", bus.overrun, 1'b0);

        // Asynchronous reset in the middle of runup.
        do_start();
        tick(RC + 5);
        chk("pre_rst_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mux", mux, M_OFF);
        chk("mid_rst_latch", cmpr_latch, 1'b1);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_valid", bus.valid, 1'b0);
        chk("mid_rst_cnt", bus.count_neg, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        do_start();
        run_conv(4'b1001, 1'b0, 2, 1'b0);

`ifdef ADC_RUNDOWN_TIMEOUT_EN
        chk("tmo_clear", bus.timeout, 1'b0);
        do_start();
        run_conv(4'b0000, 1'b0, -1, 1'b0);
        chk("tmo_set", bus.timeout, 1'b1);
        do_ack();
        chk("tmo_ack", bus.timeout, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
